// File: rtl/forward_net_pkg.sv
// Shared types and constants for the EX operand forwarding network.
package forward_net_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;

  // Producer bookkeeping; result data is kept in a parallel XLEN array.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             ready;
  } entry_t;

endpackage

// File: rtl/forward_select.sv
// Youngest-match priority search and operand mux for one EX source.
module forward_select
  import forward_net_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 3
) (
  input  entry_t [DEPTH-1:0]           ent,
  input  logic   [DEPTH-1:0][XLEN-1:0] entData,
  input  logic   [REG_W-1:0]           rs,
  input  logic   [XLEN-1:0]            regData,
  output logic   [XLEN-1:0]            data,
  output logic   [DEPTH-1:0]           hit,
  output logic                         pending
);

  // Scan oldest to youngest so the youngest match is written last.
  always_comb begin
    hit     = '0;
    data    = regData;
    pending = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent[k].valid && ent[k].rd == rs && rs != X0) begin
        hit     = '0;
        hit[k]  = 1'b1;
        data    = entData[k];
        pending = !ent[k].ready;
      end
    end
  end

endmodule

// File: rtl/forward_net.sv
// In-flight producer table with per-source forwarding and load-use stall.
module forward_net
  import forward_net_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic                       flush,
  input  logic                       ex_valid,
  input  logic                       ex_regwrite,
  input  logic                       ex_is_load,
  input  logic [REG_W-1:0]           ex_rd,
  input  logic [XLEN-1:0]            ex_result,
  input  logic [XLEN-1:0]            mem_load_data,
  input  logic [NUM_SRC*REG_W-1:0]   src_rs,
  input  logic [NUM_SRC*XLEN-1:0]    src_regdata,
  output logic [NUM_SRC*XLEN-1:0]    fwd_data,
  output logic [NUM_SRC*DEPTH-1:0]   fwd_hit,
  output logic                       load_use_stall,
  output logic [31:0]                stall_count
);

  localparam int L1 = (DEPTH > 1) ? 1 : 0;

  entry_t [DEPTH-1:0]           ent;
  logic   [DEPTH-1:0][XLEN-1:0] entData;
  logic   [NUM_SRC-1:0]         pend;
  logic                         newValid;
  logic                         loadPending;

  for (genvar s = 0; s < NUM_SRC; s++) begin : gSrc
    forward_select #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
    ) uSel (
      .ent     (ent),
      .entData (entData),
      .rs      (src_rs[s*REG_W +: REG_W]),
      .regData (src_regdata[s*XLEN +: XLEN]),
      .data    (fwd_data[s*XLEN +: XLEN]),
      .hit     (fwd_hit[s*DEPTH +: DEPTH]),
      .pending (pend[s])
    );
  end

  assign load_use_stall = ex_valid & (|pend);

  // A stalled or flushed EX instruction enters the table as a bubble.
  assign newValid = ex_valid & ex_regwrite & (ex_rd != X0)
                  & ~flush & ~load_use_stall;

  assign loadPending = ent[0].valid & ~ent[0].ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent         <= '0;
      entData     <= '0;
      stall_count <= '0;
    end else if (!hold) begin
      ent[0].valid <= newValid;
      ent[0].rd    <= ex_rd;
      ent[0].ready <= ~ex_is_load;
      entData[0]   <= ex_result;
      for (int k = 1; k < DEPTH; k++) begin
        ent[k]     <= ent[k-1];
        entData[k] <= entData[k-1];
      end
      // Load data returns while the load moves from MEM into WB.
      if (DEPTH > 1 && loadPending) begin
        ent[L1].ready <= 1'b1;
        entData[L1]   <= mem_load_data;
      end
      if (load_use_stall && stall_count != 32'hFFFF_FFFF) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: doc/forward_net.md
FORWARD_NET -- requirements
Module: forward_net

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of EX source operands forwarded.
REQ-003 SHALL have parameter DEPTH, default 3, number of in-flight producer stages tracked (entry 0 = MEM, entry 1 = WB, entry 2+ = post-WB).
REQ-004 SHALL have ports clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports hold  in  1  global pipeline freeze; flush  in  1  kill instruction in EX.
REQ-006 SHALL have ports ex_valid  in  1, ex_regwrite  in  1, ex_is_load  in  1, ex_rd  in  5, ex_result  in  XLEN: the producer leaving EX.
REQ-007 SHALL have ports mem_load_data  in  XLEN: load data for the load in entry 0.
REQ-008 SHALL have ports src_rs  in  NUM_SRC*5, src_regdata  in  NUM_SRC*XLEN: register-file read per source.
REQ-009 SHALL have ports fwd_data  out  NUM_SRC*XLEN; fwd_hit  out  NUM_SRC*DEPTH (one-hot matching entry per source, all-zero = register file).
REQ-010 SHALL have ports load_use_stall  out  1; stall_count  out  32.

Function
REQ-011 SHALL hold a table of DEPTH entries {valid, rd, ready, data}.
REQ-012 SHALL advance the table each cycle hold=0; with hold=1 all entries, stall_count and outputs derived from them SHALL be unchanged.
REQ-013 On advance, entry k SHALL take entry k-1 for k>=1.
REQ-014 On advance, entry 0 SHALL load valid = ex_valid & ex_regwrite & (ex_rd!=0) & !flush & !load_use_stall, rd = ex_rd, ready = !ex_is_load, data = ex_result.
REQ-015 On advance, if entry 0 is valid and not ready, entry 1 SHALL take data = mem_load_data and ready = 1.
REQ-016 Per source s, a match SHALL be entry k with valid, rd == rs_s and rs_s != 0.
REQ-017 The lowest-index (youngest) match SHALL win; fwd_hit SHALL be one-hot on it.
REQ-018 fwd_data_s SHALL equal the winning entry's data; with no match, src_regdata_s.
REQ-019 rs_s = 0 SHALL always select src_regdata_s and never raise a hazard.
REQ-020 load_use_stall SHALL be 1 when any source's winning match has ready = 0 and ex_valid = 1; it SHALL be combinational from the table and inputs.
REQ-021 During load_use_stall the EX instruction SHALL be converted to a bubble in entry 0 (REQ-014) while older entries advance, so the stall lasts exactly one cycle for a single load.
REQ-022 flush and load_use_stall in the same cycle SHALL produce a single bubble; flush has no other effect.
REQ-023 stall_count SHALL increment by 1 on each non-hold cycle with load_use_stall = 1, saturating at 0xFFFF_FFFF.
REQ-024 Entries beyond DEPTH-1 SHALL be discarded; producers older than DEPTH SHALL be served only by src_regdata.

Reset
REQ-025 On rising clk with rst_n = 0, all entry valid, ready, rd and data bits SHALL clear to 0 and stall_count to 0; reset SHALL override hold and flush.
REQ-026 Out of reset, fwd_hit SHALL be 0, fwd_data SHALL equal src_regdata and load_use_stall SHALL be 0.

Structure
REQ-027 A shared package SHALL hold the entry record type, the register-index width (5) and the x0 constant.
REQ-028 One sub-module, forward_select, SHALL implement the per-source priority search and mux, instantiated NUM_SRC times.

Verification
REQ-029 ALU chain: x5 <= 0x10 then consumer rs1 = x5 next cycle -> fwd_hit_0 = 001, fwd_data_0 = 0x10, no stall.
REQ-030 Double producer: x5 <= 1 then x5 <= 2 then consumer rs1 = x5 -> entry 0 wins, fwd_data_0 = 2.
REQ-031 Load-use: load x7 (mem_load_data = 0xDEAD) then consumer rs2 = x7 -> load_use_stall = 1 one cycle, stall_count = 1, next cycle fwd_hit_1 = 010, fwd_data_1 = 0xDEAD.
REQ-032 x0 target: ex_rd = 0 with ex_result = 0x55, consumer rs1 = 0 -> fwd_hit_0 = 0, fwd_data_0 = src_regdata_0.
REQ-033 Hold/flush: hold = 1 for 3 cycles mid-chain -> table and stall_count frozen; flush with producer x9 -> later x9 consumer reads register file.
REQ-034 Reset mid-operation: rst_n = 0 with 3 valid entries -> next cycle fwd_hit = 0, stall_count = 0.
